truth_table_sweeper: RTL and testbench
======================================

# truth_table_sweeper

Exhaustive stimulus-and-capture stage for 4-input combinational function blocks. On `start` it drives all 16 input vectors onto a, b, c, d in ascending order, holds each vector for a fixed number of clocks, and samples the function output once per vector. It assembles the samples into a 16-bit truth table and compares that table against an expected signature. It sits directly upstream of the function under test, feeding its inputs, and directly downstream of it, consuming its output.

## Interface
- `HOLD_CYCLES`, default 15: clocks each vector is held; legal range ≥1.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  sweep request; accepted only in IDLE.
- `expected`  in  16  expected truth table; bit i is the output for vector i; latched on start acceptance.
- `dut_out`  in  1  output of the function under test.
- `a`, `b`, `c`, `d`  out  1 each  drive to the function under test; {a,b,c,d} = vector index, with a as the MSB.
- `busy`  out  1  high while the sweep runs.
- `done`  out  1  one-cycle pulse at sweep completion.
- `captured`  out  16  sampled truth table; bit i is the sample for vector i.
- `pass`  out  1  captured == latched expected; valid from `done`, held until the next start.
- `mismatch_count`  out  5  number of differing bits, 0..16.
- `first_fail_idx`  out  4  lowest vector index that mismatched.
- `first_fail_valid`  out  1  at least one mismatch occurred.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - a..d = 0000, busy = 0.
  - `start`=1 at a rising edge moves to RUN. In that cycle: latch `expected`; clear captured, mismatch_count, first_fail_*, and pass; set idx = 0 and hold counter = 0.
- RUN:
  - {a,b,c,d} = idx, registered.
  - The hold counter counts 0..HOLD_CYCLES-1.
  - At counter == HOLD_CYCLES-1, sample `dut_out` into captured[idx]. If the sample differs from expected_q[idx]:
    - increment mismatch_count;
    - if first_fail_valid == 0, set first_fail_idx = idx and first_fail_valid = 1.
  - After sampling: if idx == 15, go to DONE; otherwise idx += 1 and counter = 0.
- DONE:
  - Lasts one cycle: done = 1, busy = 0, a..d = 0000.
  - pass = (final captured == expected_q). For idx 15 this uses the value sampled at the DONE entry edge.
  - Then go to IDLE.
- `start` in RUN or DONE is ignored and never queued.
- Results (captured, pass, mismatch_count, first_fail_*) hold until the next accepted start.
- `expected` changing during RUN has no effect.

## Timing
- Reset values: a = b = c = d = 0, busy = 0, done = 0, captured = 0, pass = 0, mismatch_count = 0, first_fail_idx = 0, first_fail_valid = 0. FSM = IDLE, idx = 0, counter = 0.
- Reset asserted mid-sweep clears all of the above immediately, independent of the clock. No done pulse is produced. The first edge after release is in IDLE.
- Start acceptance edge E0:
  - busy = 1 and a..d = 0000 after E0.
  - Vector i is driven from edge E0+i·HOLD_CYCLES to E0+(i+1)·HOLD_CYCLES.
  - `dut_out` is sampled at edge E0+(i+1)·HOLD_CYCLES − 0 (the edge ending vector i's last hold cycle). The function under test is combinational and settles within one clock.
- done rises and busy falls at edge E0+16·HOLD_CYCLES. With HOLD_CYCLES=15, that is 240 clocks after acceptance.
- done falls one clock later. The earliest next acceptance is the edge after done falls.
- HOLD_CYCLES=1: a new vector every clock; the sweep is 16 clocks.
- mismatch_count saturates naturally at 16; no wrap is possible in 5 bits.

## Test plan
- Reset, then idle 10 clocks -> all outputs at reset values; a..d stay 0000; no done.
- `dut_out` = (a&b)|(c&d), expected = 16'hF888, HOLD_CYCLES=15, start -> done exactly 240 clocks after acceptance; captured = F888; pass = 1; mismatch_count = 0; first_fail_valid = 0.
- `dut_out` stuck at 0, expected = F888 -> captured = 0000; pass = 0; mismatch_count = 7; first_fail_idx = 3; first_fail_valid = 1.
- Monitor a..d during a sweep -> each vector is stable for exactly 15 clocks; order 0000, 0001, …, 1111; busy is high throughout; start pulses mid-sweep are ignored and do not extend it.
- Assert rst_n low at vector 9 -> outputs clear asynchronously with no done. After release, start with `dut_out` = constant 1 and expected = FFFF -> pass = 1 and mismatch_count = 0, with no stale first_fail.
- HOLD_CYCLES=1, `dut_out` = a^b^c^d, expected = 16'h6996 -> done 16 clocks after acceptance; pass = 1. Start held high continuously -> a new sweep is accepted on the edge after each done falls.

Source files
------------

// File: rtl/truth_table_sweeper.sv
// Exhaustive 4-input truth-table sweeper: walks vectors 0..15 onto a..d, samples the
// function output once per vector and scores the captured table against an expected one.
module truth_table_sweeper #(
    parameter int HOLD_CYCLES = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] expected,
    input  logic        dut_out,
    output logic        a,
    output logic        b,
    output logic        c,
    output logic        d,
    output logic        busy,
    output logic        done,
    output logic [15:0] captured,
    output logic        pass,
    output logic [4:0]  mismatch_count,
    output logic [3:0]  first_fail_idx,
    output logic        first_fail_valid
);

    localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [15:0]   expected_q, expected_d;
    logic [15:0]   captured_q, captured_d;
    logic          pass_q, pass_d;
    logic [4:0]    mm_q, mm_d;
    logic [3:0]    ffi_q, ffi_d;
    logic          ffv_q, ffv_d;
    logic [15:0]   capt_upd;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idx_q      <= 4'd0;
            cnt_q      <= '0;
            expected_q <= 16'd0;
            captured_q <= 16'd0;
            pass_q     <= 1'b0;
            mm_q       <= 5'd0;
            ffi_q      <= 4'd0;
            ffv_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            expected_q <= expected_d;
            captured_q <= captured_d;
            pass_q     <= pass_d;
            mm_q       <= mm_d;
            ffi_q      <= ffi_d;
            ffv_q      <= ffv_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        expected_d = expected_q;
        captured_d = captured_q;
        pass_d     = pass_q;
        mm_d       = mm_q;
        ffi_d      = ffi_q;
        ffv_d      = ffv_q;
        capt_upd   = captured_q;
        capt_upd[idx_q] = dut_out;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = RUN;
                    expected_d = expected;
                    captured_d = 16'd0;
                    pass_d     = 1'b0;
                    mm_d       = 5'd0;
                    ffi_d      = 4'd0;
                    ffv_d      = 1'b0;
                    idx_d      = 4'd0;
                    cnt_d      = '0;
                end
            end
            RUN: begin
                if (cnt_q == CNT_LAST) begin
                    captured_d = capt_upd;
                    if (dut_out != expected_q[idx_q]) begin
                        mm_d = mm_q + 5'd1;
                        if (!ffv_q) begin
                            ffi_d = idx_q;
                            ffv_d = 1'b1;
                        end
                    end
                    cnt_d = '0;
                    if (idx_q == 4'd15) begin
                        // Score with the just-sampled bit so pass is valid alongside done.
                        state_d = DONE;
                        idx_d   = 4'd0;
                        pass_d  = (capt_upd == expected_q);
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // idx_q is held at zero outside RUN, so it drives the vector directly.
    assign {a, b, c, d}      = idx_q;
    assign busy              = (state_q == RUN);
    assign done              = (state_q == DONE);
    assign captured          = captured_q;
    assign pass              = pass_q;
    assign mismatch_count    = mm_q;
    assign first_fail_idx    = ffi_q;
    assign first_fail_valid  = ffv_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Scoreboard bench for truth_table_sweeper: one instance at HOLD_CYCLES=15, one at 1.
module tb_truth_table_sweeper;

    typedef struct {
        logic [15:0] cap;
        logic        pass;
        logic [4:0]  mm;
        logic [3:0]  ffi;
        logic        ffv;
        int          acc;
        int          lat;
    } exp_t;

    exp_t q15[$];
    exp_t q1[$];

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic        start15 = 1'b0, start1 = 1'b0;
    logic [15:0] exp15 = 16'd0, exp1 = 16'd0;
    int          mode15 = 0, mode1 = 0;
    logic        out15, out1;
    logic        a15, b15, c15, d15, busy15, done15, pass15, ffv15;
    logic        a1, b1, c1, d1, busy1, done1, pass1, ffv1;
    logic [15:0] cap15, cap1;
    logic [4:0]  mm15, mm1;
    logic [3:0]  ffi15, ffi1;

    logic act15 = 1'b0;
    int   acc15 = 0;
    int   vec_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    truth_table_sweeper #(.HOLD_CYCLES(15)) dut15 (
        .clk(clk), .rst_n(rst_n), .start(start15), .expected(exp15), .dut_out(out15),
        .a(a15), .b(b15), .c(c15), .d(d15), .busy(busy15), .done(done15),
        .captured(cap15), .pass(pass15), .mismatch_count(mm15),
        .first_fail_idx(ffi15), .first_fail_valid(ffv15)
    );

    truth_table_sweeper #(.HOLD_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .expected(exp1), .dut_out(out1),
        .a(a1), .b(b1), .c(c1), .d(d1), .busy(busy1), .done(done1),
        .captured(cap1), .pass(pass1), .mismatch_count(mm1),
        .first_fail_idx(ffi1), .first_fail_valid(ffv1)
    );

    // Functions under test, selected per sweep.
    always_comb begin
        case (mode15)
            0:       out15 = (a15 & b15) | (c15 & d15);
            1:       out15 = 1'b0;
            2:       out15 = 1'b1;
            default: out15 = a15;
        endcase
        case (mode1)
            0:       out1 = a1 ^ b1 ^ c1 ^ d1;
            default: out1 = d1;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic compare(input string tag, input exp_t e, input logic [15:0] cap, input logic p,
                           input logic [4:0] mm, input logic [3:0] ffi, input logic ffv);
        check({tag, ".captured"}, 32'(cap), 32'(e.cap));
        check({tag, ".pass"}, 32'(p), 32'(e.pass));
        check({tag, ".mismatch_count"}, 32'(mm), 32'(e.mm));
        check({tag, ".first_fail_idx"}, 32'(ffi), 32'(e.ffi));
        check({tag, ".first_fail_valid"}, 32'(ffv), 32'(e.ffv));
        check({tag, ".latency"}, 32'(cyc - e.acc), 32'(e.lat));
        $display("[TB] %s sweep: captured=%04h pass=%0d mm=%0d ffi=%0d ffv=%0d latency=%0d",
                 tag, cap, p, mm, ffi, ffv, cyc - e.acc);
    endtask

    // Monitor for HOLD_CYCLES=15: vector sequence tracking plus scoreboard pop on done.
    always @(negedge clk) begin
        if (act15 && (cyc - acc15) < 240) begin
            if (!busy15 || ({a15, b15, c15, d15} != 4'((cyc - acc15) / 15)))
                vec_err++;
        end
        if (done15) begin
            if (q15.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL h15.unexpected_done: got done=1, required done=0");
            end else begin
                exp_t e;
                e = q15.pop_front();
                compare("h15", e, cap15, pass15, mm15, ffi15, ffv15);
                check("h15.vector_sequence_errors", 32'(vec_err), 32'd0);
            end
            vec_err = 0;
            act15 = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (done1) begin
            if (q1.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL h1.unexpected_done: got done=1, required done=0");
            end else begin
                exp_t e;
                e = q1.pop_front();
                compare("h1", e, cap1, pass1, mm1, ffi1, ffv1);
            end
        end
    end

    task automatic push15(input logic [15:0] cap, input logic p, input logic [4:0] mm,
                          input logic [3:0] ffi, input logic ffv, input int acc);
        exp_t e;
        e.cap = cap; e.pass = p; e.mm = mm; e.ffi = ffi; e.ffv = ffv; e.acc = acc; e.lat = 240;
        q15.push_back(e);
    endtask

    task automatic push1(input logic [15:0] cap, input logic p, input logic [4:0] mm,
                         input logic [3:0] ffi, input logic ffv, input int acc);
        exp_t e;
        e.cap = cap; e.pass = p; e.mm = mm; e.ffi = ffi; e.ffv = ffv; e.acc = acc; e.lat = 16;
        q1.push_back(e);
    endtask

    task automatic go15(input int mode, input logic [15:0] expv);
        @(negedge clk);
        mode15 = mode;
        exp15 = expv;
        start15 = 1'b1;
        @(negedge clk);
        start15 = 1'b0;
        acc15 = cyc;
        act15 = 1'b1;
    endtask

    task automatic wait_done15(input int budget);
        int n = 0;
        @(negedge clk);
        while (!done15 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!done15) begin
            tests++;
            fails++;
            $display("FAIL h15.done_timeout: got no done in %0d clocks, required done", budget);
        end
    endtask

    task automatic wait_done1(input int budget);
        int n = 0;
        @(negedge clk);
        while (!done1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!done1) begin
            tests++;
            fails++;
            $display("FAIL h1.done_timeout: got no done in %0d clocks, required done", budget);
        end
    endtask

    initial begin
        int idle_err;
        int acc;

        #23 rst_n = 1'b1;
        @(negedge clk);
        check("reset.abcd", 32'({a15, b15, c15, d15}), 32'd0);
        check("reset.busy", 32'(busy15), 32'd0);
        check("reset.done", 32'(done15), 32'd0);
        check("reset.captured", 32'(cap15), 32'd0);
        check("reset.pass", 32'(pass15), 32'd0);
        check("reset.mismatch_count", 32'(mm15), 32'd0);
        check("reset.first_fail", 32'({ffv15, ffi15}), 32'd0);
        idle_err = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if ({a15, b15, c15, d15} != 4'd0 || busy15 || done15) idle_err++;
        end
        check("idle.outputs_quiet", 32'(idle_err), 32'd0);

        // Correct function; a mid-sweep start pulse must not extend the sweep.
        go15(0, 16'hF888);
        push15(16'hF888, 1'b1, 5'd0, 4'd0, 1'b0, acc15);
        repeat (100) @(negedge clk);
        start15 = 1'b1;
        @(negedge clk);
        start15 = 1'b0;
        wait_done15(300);
        repeat (5) @(negedge clk);
        check("h15.idle_after_ignored_start", 32'(busy15), 32'd0);

        // Stuck-at-0; expected changing mid-run must not matter.
        go15(1, 16'hF888);
        push15(16'h0000, 1'b0, 5'd7, 4'd3, 1'b1, acc15);
        repeat (20) @(negedge clk);
        exp15 = 16'h0000;
        wait_done15(300);

        // dut_out = a gives FF00 against F888.
        go15(3, 16'hF888);
        push15(16'hFF00, 1'b0, 5'd5, 4'd3, 1'b1, acc15);
        wait_done15(300);

        // Reset in the middle of vector 9 with a failing function.
        go15(1, 16'hF888);
        repeat (140) @(negedge clk);
        #2;
        rst_n = 1'b0;
        act15 = 1'b0;
        #1;
        check("async_reset.abcd", 32'({a15, b15, c15, d15}), 32'd0);
        check("async_reset.busy", 32'(busy15), 32'd0);
        check("async_reset.captured", 32'(cap15), 32'd0);
        check("async_reset.mismatch_count", 32'(mm15), 32'd0);
        check("async_reset.first_fail", 32'({ffv15, ffi15}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        go15(2, 16'hFFFF);
        push15(16'hFFFF, 1'b1, 5'd0, 4'd0, 1'b0, acc15);
        wait_done15(300);

        // HOLD_CYCLES=1 instance.
        @(negedge clk);
        mode1 = 0; exp1 = 16'h6996; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        push1(16'h6996, 1'b1, 5'd0, 4'd0, 1'b0, cyc);
        wait_done1(40);

        @(negedge clk);
        mode1 = 1; exp1 = 16'h6996; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        push1(16'hAAAA, 1'b0, 5'd8, 4'd2, 1'b1, cyc);
        wait_done1(40);

        // Start held high: back-to-back sweeps 18 clocks apart.
        repeat (2) @(negedge clk);
        mode1 = 0; exp1 = 16'h6996; start1 = 1'b1;
        @(negedge clk);
        acc = cyc;
        push1(16'h6996, 1'b1, 5'd0, 4'd0, 1'b0, acc);
        push1(16'h6996, 1'b1, 5'd0, 4'd0, 1'b0, acc + 18);
        push1(16'h6996, 1'b1, 5'd0, 4'd0, 1'b0, acc + 36);
        repeat (52) @(negedge clk);
        start1 = 1'b0;
        repeat (10) @(negedge clk);

        check("h15.scoreboard_drained", 32'(q15.size()), 32'd0);
        check("h1.scoreboard_drained", 32'(q1.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
